// File: rtl/udm_pkg.sv
// Shared definitions for the UDM frame decoder: command codes, the default
// frame start marker and the decoder FSM state encoding.
package udm_pkg;

  localparam logic [7:0] UDM_CMD_WR       = 8'h01;
  localparam logic [7:0] UDM_CMD_RD       = 8'h02;
  localparam logic [7:0] UDM_SYNC_DEFAULT = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_HOLD = 3'd4
  } udm_state_t;

endpackage

// File: rtl/udm_timeout_timer.sv
// Inter-byte watchdog for the UDM frame decoder. Counts idle cycles while a
// frame is in progress and raises a single-cycle expiry when the limit is hit.
module udm_timeout_timer #(
  parameter logic [31:0] LIMIT = 32'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [31:0] count;

  assign expired = run && !clear && (count == LIMIT - 32'd1);

  // Count idle cycles inside a frame; any byte, expiry or leaving the frame restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (!run || clear || expired) begin
      count <= 32'd0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/udm_frame_decoder.sv
// UDM frame decoder: turns a UART byte stream (SYNC, CMD, ADDR, [DATA]) into a
// single read/write command held behind a valid/ready handshake.
// Optional inter-byte timeout is enabled by defining UDM_FRAME_TIMEOUT_EN.
module udm_frame_decoder
  import udm_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter logic [7:0]  SYNC_BYTE      = UDM_SYNC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        locked_i,
  input  logic        rx_done_tick_i,
  input  logic [7:0]  rx_data_bi,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        cmd_we_o,
  output logic [31:0] cmd_addr_bo,
  output logic [31:0] cmd_wdata_bo,
  output logic        err_o,
  output logic        ovf_o
);

  udm_state_t  state;
  udm_state_t  state_next;
  logic [1:0]  byte_cnt;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err;
  logic        ovf;

  logic        cmd_latch;
  logic        shift_addr;
  logic        shift_data;
  logic        err_set;
  logic        ovf_set;
  logic        timeout_hit;

`ifdef UDM_FRAME_TIMEOUT_EN
  logic frame_active;

  assign frame_active = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);

  udm_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .run     (frame_active),
    .clear   (rx_done_tick_i),
    .expired (timeout_hit)
  );
`else
  // Without the watchdog a partial frame waits forever; the parameter is still referenced.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; lock loss aborts any frame but never a pending command.
  always_comb begin
    state_next = state;
    cmd_latch  = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    err_set    = 1'b0;
    ovf_set    = 1'b0;
    if (state != ST_HOLD && !locked_i) begin
      state_next = ST_IDLE;
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
      err_set    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_done_tick_i && rx_data_bi == SYNC_BYTE) state_next = ST_CMD;
        end
        ST_CMD: begin
          if (rx_done_tick_i) begin
            if (rx_data_bi == UDM_CMD_WR || rx_data_bi == UDM_CMD_RD) begin
              cmd_latch  = 1'b1;
              state_next = ST_ADDR;
            end else begin
              err_set    = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_ADDR: begin
          if (rx_done_tick_i) begin
            shift_addr = 1'b1;
            if (byte_cnt == 2'd3) state_next = cmd_we ? ST_DATA : ST_HOLD;
          end
        end
        ST_DATA: begin
          if (rx_done_tick_i) begin
            shift_data = 1'b1;
            if (byte_cnt == 2'd3) state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rx_done_tick_i) ovf_set = 1'b1;
          if (cmd_ready_i) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Command fields, byte counter and the one-cycle error/overflow pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_cnt  <= 2'd0;
      cmd_we    <= 1'b0;
      cmd_addr  <= 32'd0;
      cmd_wdata <= 32'd0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      err <= err_set;
      ovf <= ovf_set;
      if (cmd_latch) begin
        cmd_we <= (rx_data_bi == UDM_CMD_WR);
        if (rx_data_bi != UDM_CMD_WR) cmd_wdata <= 32'd0;
      end
      if (shift_addr) cmd_addr[{byte_cnt, 3'b000} +: 8] <= rx_data_bi;
      if (shift_data) cmd_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data_bi;
      if (state_next == ST_IDLE) begin
        byte_cnt <= 2'd0;
      end else if (shift_addr || shift_data) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  assign cmd_valid_o  = (state == ST_HOLD);
  assign cmd_we_o     = cmd_we;
  assign cmd_addr_bo  = cmd_addr;
  assign cmd_wdata_bo = cmd_wdata;
  assign err_o        = err;
  assign ovf_o        = ovf;

endmodule

// File: tb/tb_udm_frame_decoder.sv
// Self-checking bench for udm_frame_decoder. Expected commands are queued as
// frames are sent and compared every cycle the DUT presents cmd_valid_o.
// Honours UDM_FRAME_TIMEOUT_EN for the timeout scenario.
module tb_udm_frame_decoder;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        locked_i;
  logic        rx_done_tick_i;
  logic [7:0]  rx_data_bi;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic        cmd_we_o;
  logic [31:0] cmd_addr_bo;
  logic [31:0] cmd_wdata_bo;
  logic        err_o;
  logic        ovf_o;

  cmd_t       exp_q[$];
  logic [7:0] frame_q[$];
  int vectors      = 0;
  int miscompares  = 0;
  int valid_cycles = 0;
  int err_pulses   = 0;
  int ovf_pulses   = 0;
  int v0, e0, o0;

  udm_frame_decoder #(
    .TIMEOUT_CYCLES (32'd100),
    .SYNC_BYTE      (8'h55)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .locked_i       (locked_i),
    .rx_done_tick_i (rx_done_tick_i),
    .rx_data_bi     (rx_data_bi),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_we_o       (cmd_we_o),
    .cmd_addr_bo    (cmd_addr_bo),
    .cmd_wdata_bo   (cmd_wdata_bo),
    .err_o          (err_o),
    .ovf_o          (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic cmd_t mkCmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data_bi     = b;
    rx_done_tick_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_done_tick_i = 1'b0;
  endtask

  task automatic sendFrame();
    foreach (frame_q[i]) applyStimulus(frame_q[i]);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    checkOutput(tag, exp_q.size(), 0);
    idle(2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(cmd_valid_o), 0);
    checkOutput({tag, "_we"}, 32'(cmd_we_o), 0);
    checkOutput({tag, "_addr"}, cmd_addr_bo, 0);
    checkOutput({tag, "_wdata"}, cmd_wdata_bo, 0);
    checkOutput({tag, "_err"}, 32'(err_o), 0);
    checkOutput({tag, "_ovf"}, 32'(ovf_o), 0);
  endtask

  // Scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (err_o) err_pulses++;
      if (ovf_o) ovf_pulses++;
      if (cmd_valid_o) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'(cmd_valid_o), 0);
        end else begin
          checkOutput("cmd_we", 32'(cmd_we_o), 32'(exp_q[0].we));
          checkOutput("cmd_addr", cmd_addr_bo, exp_q[0].addr);
          checkOutput("cmd_wdata", cmd_wdata_bo, exp_q[0].wdata);
          if (cmd_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    rstn_i         = 1'b0;
    locked_i       = 1'b1;
    rx_done_tick_i = 1'b0;
    rx_data_bi     = 8'h00;
    cmd_ready_i    = 1'b1;
    idle(3);
    checkAllZero("reset");
    rstn_i = 1'b1;
    idle(2);

    $display("[TB] write frame, ready high");
    v0 = valid_cycles;
    exp_q.push_back(mkCmd(1'b1, 32'h12345678, 32'hDEADBEEF));
    frame_q = '{8'hAA, 8'h55, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendFrame();
    waitDrain("t1_drain");
    checkOutput("t1_valid_cycles", valid_cycles - v0, 1);

    $display("[TB] read frame, ready held low 20 cycles");
    v0 = valid_cycles;
    cmd_ready_i = 1'b0;
    exp_q.push_back(mkCmd(1'b0, 32'h80000004, 32'h0));
    frame_q = '{8'h55, 8'h02, 8'h04, 8'h00, 8'h00, 8'h80};
    sendFrame();
    idle(20);
    cmd_ready_i = 1'b1;
    waitDrain("t2_drain");
    checkOutput("t2_valid_cycles", valid_cycles - v0, 21);
    checkOutput("t2_idle_valid", 32'(cmd_valid_o), 0);

    $display("[TB] invalid command then normal read");
    v0 = valid_cycles;
    e0 = err_pulses;
    frame_q = '{8'h55, 8'h7F};
    sendFrame();
    idle(3);
    checkOutput("t3_err_pulses", err_pulses - e0, 1);
    checkOutput("t3_no_valid", valid_cycles - v0, 0);
    exp_q.push_back(mkCmd(1'b0, 32'h0, 32'h0));
    frame_q = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    sendFrame();
    waitDrain("t3_drain");

    $display("[TB] overflow in hold and on acceptance cycle");
    o0 = ovf_pulses;
    e0 = err_pulses;
    cmd_ready_i = 1'b0;
    exp_q.push_back(mkCmd(1'b0, 32'hCAFE0010, 32'h0));
    frame_q = '{8'h55, 8'h02, 8'h10, 8'h00, 8'hFE, 8'hCA};
    sendFrame();
    idle(2);
    applyStimulus(8'hA5);
    idle(2);
    checkOutput("t4_ovf_hold", ovf_pulses - o0, 1);
    checkOutput("t4_still_valid", 32'(cmd_valid_o), 1);
    cmd_ready_i = 1'b1;
    applyStimulus(8'h55);
    idle(2);
    checkOutput("t4_ovf_accept", ovf_pulses - o0, 2);
    checkOutput("t4_popped", exp_q.size(), 0);
    exp_q.push_back(mkCmd(1'b1, 32'hA5A5A5A5, 32'h01020304));
    frame_q = '{8'h55, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h04, 8'h03, 8'h02, 8'h01};
    sendFrame();
    waitDrain("t4_drain");
    checkOutput("t4_no_err", err_pulses - e0, 0);

    $display("[TB] reset mid-frame");
    frame_q = '{8'h55, 8'h01, 8'h11, 8'h22};
    sendFrame();
    rstn_i = 1'b0;
    #1;
    checkAllZero("midrst");
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    idle(1);
    v0 = valid_cycles;
    exp_q.push_back(mkCmd(1'b1, 32'h0BADF00D, 32'h13579BDF));
    frame_q = '{8'h55, 8'h01, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'hDF, 8'h9B, 8'h57, 8'h13};
    sendFrame();
    waitDrain("t5_drain");
    checkOutput("t5_valid_cycles", valid_cycles - v0, 1);

    $display("[TB] lock loss mid-frame");
    e0 = err_pulses;
    frame_q = '{8'h55, 8'h01, 8'hAA};
    sendFrame();
    locked_i = 1'b0;
    idle(1);
    locked_i = 1'b1;
    exp_q.push_back(mkCmd(1'b0, 32'h00C0FFEE, 32'h0));
    frame_q = '{8'h55, 8'h02, 8'hEE, 8'hFF, 8'hC0, 8'h00};
    sendFrame();
    waitDrain("t6_drain");
    checkOutput("t6_no_err", err_pulses - e0, 0);

    $display("[TB] silence inside a frame");
    e0 = err_pulses;
    frame_q = '{8'h55, 8'h01, 8'h11};
    sendFrame();
    idle(150);
`ifdef UDM_FRAME_TIMEOUT_EN
    checkOutput("t7_timeout_err", err_pulses - e0, 1);
    exp_q.push_back(mkCmd(1'b0, 32'h76543210, 32'h0));
    frame_q = '{8'h55, 8'h02, 8'h10, 8'h32, 8'h54, 8'h76};
    sendFrame();
    waitDrain("t7_drain");
`else
    checkOutput("t7_no_err", err_pulses - e0, 0);
    exp_q.push_back(mkCmd(1'b1, 32'h44332211, 32'h88776655));
    frame_q = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sendFrame();
    waitDrain("t7_drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udm_frame_decoder.md
UDM_FRAME_DECODER -- requirements
Module: udm_frame_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd1000000: inter-byte timeout in clk_i cycles (used only with UDM_FRAME_TIMEOUT_EN).
REQ-002 Parameter SYNC_BYTE, default 8'h55: frame start marker.
REQ-003 clk_i  in  1  single clock; all logic on posedge clk_i.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 locked_i  in  1  UART receiver baud lock indication.
REQ-006 rx_done_tick_i  in  1  one-cycle pulse, byte valid on rx_data_bi.
REQ-007 rx_data_bi  in  8  received byte.
REQ-008 cmd_valid_o  out  1  decoded command pending.
REQ-009 cmd_ready_i  in  1  consumer accepts the command.
REQ-010 cmd_we_o  out  1  1 = write, 0 = read.
REQ-011 cmd_addr_bo  out  32  command address.
REQ-012 cmd_wdata_bo  out  32  write data (0 for reads).
REQ-013 err_o  out  1  one-cycle pulse on an unknown command byte.
REQ-014 ovf_o  out  1  one-cycle pulse when a byte is dropped during HOLD.

Function
REQ-015 Frame: SYNC_BYTE, CMD, ADDR[7:0]..ADDR[31:24], then, for writes only, DATA[7:0]..DATA[31:24]; multi-byte fields little-endian.
REQ-016 CMD 8'h01 = write, 8'h02 = read; all other values are invalid.
REQ-017 States: IDLE, CMD, ADDR, DATA, HOLD; the FSM advances only on rx_done_tick_i, except in HOLD.
REQ-018 IDLE: a byte equal to SYNC_BYTE -> CMD; any other byte is ignored and the FSM stays in IDLE.
REQ-019 CMD: byte 01/02 latches cmd_we_o and goes to ADDR; an invalid byte pulses err_o on the next cycle and returns to IDLE.
REQ-020 ADDR/DATA: a 2-bit byte counter shifts each byte into bits [8*n+7:8*n]; after the 4th byte the counter wraps to 0.
- ADDR -> DATA for a write, ADDR -> HOLD for a read.
- DATA -> HOLD.
REQ-021 Entering HOLD sets cmd_valid_o on the cycle after the last byte's tick (latency 1 clk).
REQ-022 HOLD: cmd_valid_o, cmd_we_o, cmd_addr_bo and cmd_wdata_bo stay stable until cmd_valid_o && cmd_ready_i; on that cycle the FSM goes to IDLE and cmd_valid_o clears the next cycle.
REQ-023 A tick in HOLD drops the byte and pulses ovf_o for one cycle; cmd_valid_o is unaffected.
REQ-024 A tick coincident with the acceptance cycle is dropped and flagged the same way.
REQ-025 A read command loads cmd_wdata_bo with 32'h0.
REQ-026 locked_i low, sampled in any state other than HOLD, forces IDLE on the next cycle.
- In HOLD the pending command completes its handshake first.
REQ-027 The lock-acknowledge 0x55 byte from the receiver is a legal SYNC.

Reset
REQ-028 While rstn_i is low: state = IDLE, byte counter = 0, and every output = 0 (cmd_valid_o, cmd_we_o, cmd_addr_bo, cmd_wdata_bo, err_o, ovf_o).
REQ-029 Reset asserted mid-frame or during HOLD discards the partial or pending command; no handshake completes.

Configuration
REQ-030 UDM_FRAME_TIMEOUT_EN defined: a 32-bit counter clears on each tick and increments otherwise in CMD/ADDR/DATA; when it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE and err_o pulses once.
- The counter is held at 0 in IDLE and HOLD.
REQ-031 UDM_FRAME_TIMEOUT_EN undefined: no counter; partial frames wait indefinitely.

Structure
REQ-032 Package udm_pkg holds the command code constants (UDM_CMD_WR = 8'h01, UDM_CMD_RD = 8'h02), the SYNC default and the FSM state encoding.
REQ-033 One sub-module, udm_timeout_timer (counter plus expiry pulse), instantiated only under UDM_FRAME_TIMEOUT_EN.

Verification
REQ-034 Bytes 55 01 78 56 34 12 EF BE AD DE, ready=1 -> one cmd_valid_o pulse, we=1, addr=32'h12345678, wdata=32'hDEADBEEF.
REQ-035 Bytes 55 02 04 00 00 80, ready held 0 for 20 cycles then 1 -> valid stable all 21 cycles, we=0, addr=32'h80000004, wdata=0, then IDLE.
REQ-036 Bytes 55 7F -> err_o one pulse, no cmd_valid_o; next frame 55 02 00 00 00 00 decodes normally.
REQ-037 Read frame with ready=0, then byte A5 arrives -> ovf_o one pulse, command unchanged.
REQ-038 rstn_i low for 1 cycle after 55 01 11 22 -> all outputs 0; following full frame decodes correctly.
REQ-039 With UDM_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: 55 01 11 then silence -> err_o at cycle 100 after the last tick, IDLE; without the macro the FSM stays in ADDR.
